// File: rtl/snail_alu_seq.sv
// snail_alu_seq: handshaked, registered ALU with compare/status flags.
// One operation is in flight at a time.
//
// Timing:
//   - Single-cycle ops: the result is registered on the accepting edge.
//   - MUL: an iterative shift-add that finishes WIDTH edges after acceptance.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready only while idle)
//   A, B, op          operands and function code
//                       0 ADD, 1 SUB, 2 AND, 3 XOR, 4 OR, 5 SHL, 6 SHR, 7 MUL
//                       8-15 are illegal
//   out_valid/out_ready result handshake (no bypass back into idle)
//   E, E_hi           result; E_hi is the MUL high half, 0 otherwise
//   cc                {A==B, A>B} unsigned, from the captured operands
//   carry             ADD carry-out / SUB borrow, 0 otherwise
//   zero              {E_hi,E} == 0
//   err               illegal op code
module snail_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] E,
  output logic [WIDTH-1:0] E_hi,
  output logic [1:0]       cc,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  // Shift amounts use CNT_W bits of B, so amounts up to 2*WIDTH-1 are
  // representable and anything >= WIDTH flushes the result to zero.
  localparam logic [CNT_W-1:0] SH_LIM = CNT_W'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t state, nxt;

  logic [2*WIDTH-1:0] acc, mcand, acc_add;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH:0]     sum, diff;
  logic [CNT_W-1:0]   shamt;
  logic [WIDTH-1:0]   alu_e;
  logic               alu_c, alu_err;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (in_valid)  nxt = (op == OP_MUL) ? S_MUL : S_DONE;
      // Last iteration happens on the edge that takes cnt from 1 to 0.
      S_MUL:  if (cnt == CNT_W'(1)) nxt = S_DONE;
      S_DONE: if (out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Single-cycle datapath, evaluated on the live inputs at acceptance.
  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    shamt   = B[CNT_W-1:0];
    alu_e   = '0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD: begin alu_e = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  end
      OP_SUB: begin alu_e = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; end
      OP_AND: alu_e = A & B;
      OP_XOR: alu_e = A ^ B;
      OP_OR:  alu_e = A | B;
      OP_SHL: alu_e = (shamt >= SH_LIM) ? '0 : (A << shamt);
      OP_SHR: alu_e = (shamt >= SH_LIM) ? '0 : (A >> shamt);
      OP_MUL: alu_e = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // One shift-add step: the multiplicand is pre-shifted to the current bit.
  assign acc_add = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      E      <= '0;
      E_hi   <= '0;
      cc     <= 2'b00;
      carry  <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          cc <= {A == B, A > B};
          if (op == OP_MUL) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            cnt    <= CNT_W'(WIDTH);
            carry  <= 1'b0;
            err    <= 1'b0;
          end else begin
            E     <= alu_e;
            E_hi  <= '0;
            carry <= alu_c;
            err   <= alu_err;
            zero  <= (alu_e == '0);
          end
        end
        S_MUL: begin
          acc    <= acc_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            {E_hi, E} <= acc_add;
            zero      <= (acc_add == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
